// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared state encoding and sizing helpers for the AES SPI master.
package aes_spi_pkg;

    localparam int BLOCK_BITS = 128;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        TURN,
        READ,
        HOLD,
        DONE
    } state_t;

    // Key length in bits for a key of nk 32-bit words.
    function automatic int key_bits(input int nk);
        return 32 * nk;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: counts DIV clk cycles per SCLK half-period and strobes the
// cycle before SCLK should rise (rise) or fall (fall). Holding run low
// parks the divider at the start of a low half-period.
module spi_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic rise,
    output logic fall
);

    localparam int               DIV_W = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic             high;
    logic             tick;

    assign tick = run && (cnt == LAST);
    assign rise = tick && !high;
    assign fall = tick && high;

    // Half-period counter plus the SCLK phase it is timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            high <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            high <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            high <= !high;
        end else begin
            cnt  <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// aes_spi_master: bit-serial SPI master (mode 0, MSB first) that sends a
// plaintext block and key to the AES slave, idles TURN SCLK periods, then
// reads back the 128-bit ciphertext.
// Optional feature: define AES_SPI_ABORT_EN to add the abort input.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int Nk   = 4,
    parameter int DIV  = 2,
    parameter int TURN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BLOCK_BITS-1:0]   data_in,
    input  logic [key_bits(Nk)-1:0] key_in,
    output logic                    busy,
    output logic                    done,
    output logic [BLOCK_BITS-1:0]   data_out,
    output logic                    SCLK,
    output logic                    MOSI,
    input  logic                    MISO,
`ifdef AES_SPI_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    CS
);

    localparam int W     = BLOCK_BITS + key_bits(Nk);
    localparam int CNT_W = $clog2(BLOCK_BITS + key_bits(8) + TURN + 1);

    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(BLOCK_BITS - 1);

    state_t                  state,    state_nxt;
    logic [CNT_W-1:0]        bit_cnt,  bit_cnt_nxt;
    logic [W-2:0]            tx,       tx_nxt;       // bits still to send after MOSI
    logic [BLOCK_BITS-1:0]   rx,       rx_nxt;
    logic                    aborted,  aborted_nxt;
    logic                    busy_nxt, done_nxt, sclk_nxt, mosi_nxt, cs_nxt;
    logic [BLOCK_BITS-1:0]   data_out_nxt;

    logic div_run, sclk_rise, sclk_fall;
    logic abort_hit;

`ifdef AES_SPI_ABORT_EN
    assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
    assign abort_hit = 1'b0;
`endif

    spi_clk_div #(
        .DIV (DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .run  (div_run),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Next-state and next-output decode for the transaction sequencer.
    always_comb begin
        // NOTE: every next value defaults to its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        tx_nxt       = tx;
        rx_nxt       = rx;
        aborted_nxt  = aborted;
        done_nxt     = 1'b0;
        data_out_nxt = data_out;
        sclk_nxt     = SCLK;
        mosi_nxt     = MOSI;
        cs_nxt       = CS;
        div_run      = (state != IDLE) && (state != DONE) && !abort_hit;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SETUP;
                    tx_nxt      = {data_in[BLOCK_BITS-2:0], key_in};
                    mosi_nxt    = data_in[BLOCK_BITS-1];
                    cs_nxt      = 1'b0;
                    bit_cnt_nxt = '0;
                end
            end
            SETUP: begin
                // SETUP is the low half of the first bit period.
                if (sclk_rise) begin
                    state_nxt = WRITE;
                    sclk_nxt  = 1'b1;
                end
            end
            WRITE: begin
                if (sclk_rise) sclk_nxt = 1'b1;
                if (sclk_fall) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt == WRITE_LAST) begin
                        bit_cnt_nxt = '0;
                        mosi_nxt    = 1'b0;
                        if (TURN > 0) state_nxt = aes_spi_pkg::TURN;
                        else          state_nxt = READ;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        mosi_nxt    = tx[W-2];
                        tx_nxt      = {tx[W-3:0], 1'b0};
                    end
                end
            end
            aes_spi_pkg::TURN: begin
                if (sclk_rise) sclk_nxt = 1'b1;
                if (sclk_fall) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt == TURN_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = READ;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            READ: begin
                if (sclk_rise) begin
                    sclk_nxt = 1'b1;
                    rx_nxt   = {rx[BLOCK_BITS-2:0], MISO};
                end
                if (sclk_fall) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt == READ_LAST) begin
                        bit_cnt_nxt = '0;
                        cs_nxt      = 1'b1;
                        state_nxt   = HOLD;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // One divider half-period with CS high before finishing.
                if (sclk_rise) begin
                    state_nxt   = aborted ? IDLE : DONE;
                    aborted_nxt = 1'b0;
                end
            end
            DONE: begin
                state_nxt    = IDLE;
                done_nxt     = 1'b1;
                data_out_nxt = rx;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort_hit) begin
            state_nxt   = HOLD;
            aborted_nxt = 1'b1;
            bit_cnt_nxt = '0;
            cs_nxt      = 1'b1;
            sclk_nxt    = 1'b0;
            mosi_nxt    = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            // NOTE: the tx/rx shift registers are reset too: rx feeds data_out, and a reset mid-transaction must leave nothing partial behind.
            tx       <= '0;
            rx       <= '0;
            aborted  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            CS       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx       <= tx_nxt;
            rx       <= rx_nxt;
            aborted  <= aborted_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            data_out <= data_out_nxt;
            SCLK     <= sclk_nxt;
            MOSI     <= mosi_nxt;
            CS       <= cs_nxt;
        end
    end

endmodule

// File: tb/tb_aes_spi_master.sv
// tb_aes_spi_master: two configurations of aes_spi_master against a
// behavioural SPI slave/bus monitor and a spec-level timing model.
`timescale 1ns/1ps
module tb_aes_spi_master;

    localparam int NK_A = 4, DIV_A = 2, TURN_A = 1;
    localparam int NK_B = 8, DIV_B = 1, TURN_B = 0;
    localparam int KB_A = 32 * NK_A, KB_B = 32 * NK_B;
    localparam int W_A  = 128 + KB_A, W_B = 128 + KB_B;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              start_a = 1'b0, start_b = 1'b0;
    logic [127:0]      din_a = '0, din_b = '0;
    logic [KB_A-1:0]   key_a = '0;
    logic [KB_B-1:0]   key_b = '0;
    logic              busy_a, done_a, sclk_a, mosi_a, cs_a;
    logic              busy_b, done_b, sclk_b, mosi_b, cs_b;
    logic [127:0]      dout_a, dout_b;
    logic              miso_a = 1'b0, miso_b = 1'b0;
`ifdef AES_SPI_ABORT_EN
    logic              abort_a = 1'b0, abort_b = 1'b0;
`endif

    aes_spi_master #(.Nk(NK_A), .DIV(DIV_A), .TURN(TURN_A)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .data_in  (din_a),
        .key_in   (key_a),
        .busy     (busy_a),
        .done     (done_a),
        .data_out (dout_a),
        .SCLK     (sclk_a),
        .MOSI     (mosi_a),
        .MISO     (miso_a),
`ifdef AES_SPI_ABORT_EN
        .abort    (abort_a),
`endif
        .CS       (cs_a)
    );

    aes_spi_master #(.Nk(NK_B), .DIV(DIV_B), .TURN(TURN_B)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .data_in  (din_b),
        .key_in   (key_b),
        .busy     (busy_b),
        .done     (done_b),
        .data_out (dout_b),
        .SCLK     (sclk_b),
        .MOSI     (mosi_b),
        .MISO     (miso_b),
`ifdef AES_SPI_ABORT_EN
        .abort    (abort_b),
`endif
        .CS       (cs_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input int nk, input int div, input int turn);
        return 1 + div + 2 * div * ((128 + 32 * nk) + turn + 128);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Ciphertext bit the slave presents after its idx-th read bit; ones outside the read window.
    function automatic logic slave_bit(input int idx, input logic [127:0] r);
        if (idx >= 0 && idx < 128) return r[127 - idx];
        return 1'b1;
    endfunction

    // Slave responses and bus monitor state per instance.
    logic [127:0]    resp_a = '0, resp_b = '0;
    int              rises_a = 0, rises_b = 0;
    logic [W_A-1:0]  cap_a = '0;
    logic [W_B-1:0]  cap_b = '0;
    logic            hot_a = 1'b0, hot_b = 1'b0;
    logic            sclk_a_q = 1'b0, cs_a_q = 1'b1, sclk_b_q = 1'b0, cs_b_q = 1'b1;

    // Slave A: capture MOSI on SCLK rise, present ciphertext after SCLK fall.
    always @(negedge clk) begin
        if (cs_a_q && !cs_a) begin
            rises_a <= 0;
            cap_a   <= '0;
            hot_a   <= 1'b0;
        end else if (!cs_a && sclk_a && !sclk_a_q) begin
            if (rises_a < W_A) cap_a[W_A - 1 - rises_a] <= mosi_a;
            else if (mosi_a)   hot_a <= 1'b1;
            rises_a <= rises_a + 1;
        end else if (!cs_a && !sclk_a && sclk_a_q) begin
            miso_a <= slave_bit(rises_a - W_A - TURN_A, resp_a);
        end
        sclk_a_q <= sclk_a;
        cs_a_q   <= cs_a;
    end

    // Slave B: same behaviour for the second configuration.
    always @(negedge clk) begin
        if (cs_b_q && !cs_b) begin
            rises_b <= 0;
            cap_b   <= '0;
            hot_b   <= 1'b0;
        end else if (!cs_b && sclk_b && !sclk_b_q) begin
            if (rises_b < W_B) cap_b[W_B - 1 - rises_b] <= mosi_b;
            else if (mosi_b)   hot_b <= 1'b1;
            rises_b <= rises_b + 1;
        end else if (!cs_b && !sclk_b && sclk_b_q) begin
            miso_b <= slave_bit(rises_b - W_B - TURN_B, resp_b);
        end
        sclk_b_q <= sclk_b;
        cs_b_q   <= cs_b;
    end

    // One full transaction on instance sel (0=A, 1=B); optional stray start pulse at pulse_at.
    task automatic txn(input bit sel, input logic [127:0] pt, input logic [255:0] key,
                       input logic [127:0] resp, input int pulse_at, input string tag);
        int   lat;
        bit   busy_ok;
        bit   seen;
        int   exp_lat;
        int   exp_rises;
        exp_lat   = sel ? exp_latency(NK_B, DIV_B, TURN_B) : exp_latency(NK_A, DIV_A, TURN_A);
        exp_rises = sel ? (W_B + TURN_B + 128) : (W_A + TURN_A + 128);
        @(negedge clk);
        if (sel) begin din_b = pt; key_b = key; resp_b = resp; start_b = 1'b1; end
        else     begin din_a = pt; key_a = key[KB_A-1:0]; resp_a = resp; start_a = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 0; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? done_b : done_a) seen = 1'b1;
            else if (!(sel ? busy_b : busy_a)) busy_ok = 1'b0;
            if (lat == pulse_at) begin if (sel) start_b = 1'b1; else start_a = 1'b1; end
            if (lat == pulse_at + 1) begin start_a = 1'b0; start_b = 1'b0; end
        end
        check({tag, " done_seen"}, seen, 1'b1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " data_out"}, sel ? dout_b : dout_a, resp);
        check({tag, " busy_at_done"}, sel ? busy_b : busy_a, 1'b0);
        check({tag, " busy_held"}, busy_ok, 1'b1);
        check({tag, " sclk_rises"}, sel ? rises_b : rises_a, exp_rises);
        if (sel) check({tag, " mosi_bits"}, cap_b, {pt, key});
        else     check({tag, " mosi_bits"}, cap_a, {pt, key[KB_A-1:0]});
        check({tag, " mosi_quiet"}, sel ? hot_b : hot_a, 1'b0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, sel ? done_b : done_a, 1'b0);
        check({tag, " data_out_hold"}, sel ? dout_b : dout_a, resp);
    endtask

    initial begin
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a busy", busy_a, 1'b0);
        check("rst_a done", done_a, 1'b0);
        check("rst_a dout", dout_a, 128'h0);
        check("rst_a sclk", sclk_a, 1'b0);
        check("rst_a mosi", mosi_a, 1'b0);
        check("rst_a cs",   cs_a,   1'b1);
        check("rst_b busy", busy_b, 1'b0);
        check("rst_b cs",   cs_b,   1'b1);
        check("rst_b dout", dout_b, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // FIPS-197 vector with a stray start pulse at cycle 100.
        txn(1'b0, 128'h00112233445566778899aabbccddeeff,
            {128'h0, 128'h000102030405060708090a0b0c0d0e0f},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 100, "fips");
        repeat (20) @(posedge clk);
        #1;
        check("no_queued busy", busy_a, 1'b0);
        check("no_queued cs", cs_a, 1'b1);

        // Randomized transactions on configuration A.
        for (int i = 0; i < 3; i++) begin
            pt  = rnd128();
            key = {rnd128(), rnd128()};
            ct  = rnd128();
            txn(1'b0, pt, key, ct, -10, $sformatf("rand_a%0d", i));
        end

        // Asynchronous reset mid-WRITE, then recovery.
        @(negedge clk);
        din_a = rnd128(); key_a = rnd128(); resp_a = rnd128(); start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (699) @(posedge clk);
        #2;
        check("pre_rst cs_active", cs_a, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst busy", busy_a, 1'b0);
        check("mid_rst done", done_a, 1'b0);
        check("mid_rst dout", dout_a, 128'h0);
        check("mid_rst sclk", sclk_a, 1'b0);
        check("mid_rst mosi", mosi_a, 1'b0);
        check("mid_rst cs",   cs_a,   1'b1);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, rnd128(), {rnd128(), rnd128()}, rnd128(), -10, "after_rst");

        // Configuration B: DIV=1, TURN=0, Nk=8.
        txn(1'b1, rnd128(), {rnd128(), rnd128()}, {128{1'b1}}, -10, "b_ones");
        for (int i = 0; i < 2; i++) begin
            txn(1'b1, rnd128(), {rnd128(), rnd128()}, rnd128(), -10, $sformatf("rand_b%0d", i));
        end

`ifdef AES_SPI_ABORT_EN
        begin : abort_seq
            logic [127:0] prev;
            int           low_at;
            bit           dseen;
            prev = dout_a;
            @(negedge clk);
            din_a = rnd128(); key_a = rnd128(); resp_a = rnd128(); start_a = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_a = 1'b0;
            repeat (399) @(posedge clk);
            @(negedge clk);
            abort_a = 1'b1;
            @(posedge clk);
            #1;
            check("abort cs", cs_a, 1'b1);
            check("abort sclk", sclk_a, 1'b0);
            check("abort mosi", mosi_a, 1'b0);
            @(negedge clk);
            abort_a = 1'b0;
            low_at = 0;
            dseen  = 1'b0;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk);
                #1;
                if (!busy_a && low_at == 0) low_at = n;
                if (done_a) dseen = 1'b1;
            end
            check("abort busy_low", (low_at > 0) && (low_at <= DIV_A + 2), 1'b1);
            check("abort no_done", dseen, 1'b0);
            check("abort dout_kept", dout_a, prev);
            txn(1'b0, rnd128(), {rnd128(), rnd128()}, rnd128(), -10, "after_abort");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_spi_master.md
# aes_spi_master

- Bit-serial SPI master that drives the AES encryption core's SPI slave port from the system side.
- Per transaction:
  - shifts out a 128-bit plaintext block, then a 32·Nk-bit key, both MSB first;
  - waits a configurable turnaround;
  - shifts in the 128-bit ciphertext.
- Sits between a host/test controller and the encryption slave. It is the initiating end of the same serial protocol.

## Interface
Parameters:
- Nk, 4, key length in 32-bit words (4/6/8)
- DIV, 2, clk cycles per SCLK half-period (≥1)
- TURN, 1, idle SCLK periods between last key bit and first ciphertext bit (≥0)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  begin transaction; sampled only in IDLE
- data_in  in  128  plaintext; latched when start accepted
- key_in  in  32·Nk  key; latched when start accepted
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse; data_out valid from this cycle
- data_out  out  128  received ciphertext; holds until next done
- SCLK  out  1  serial clock, idle low
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave
- CS  out  1  chip select, active low

## Operation
- Reset values (rst low, asynchronous): busy=0, done=0, data_out=0, SCLK=0, MOSI=0, CS=1, state=IDLE, all counters=0.
- States:
  - IDLE: start=1 → latch {data_in, key_in} into a shift register → SETUP.
  - SETUP: CS=0, MOSI=data_in[127], for DIV cycles → WRITE.
  - WRITE: W=128+32·Nk bits.
    - SCLK rises after DIV cycles and falls DIV cycles later.
    - MOSI advances to the next bit on each falling edge.
    - After the W-th falling edge → TURN if TURN>0, else READ.
  - TURN: TURN full SCLK periods with MOSI=0; no sampling → READ.
  - READ: 128 SCLK periods, MOSI=0.
    - MISO is sampled on the clk cycle SCLK rises.
    - Data shifts in LSB-ward, so the first sampled bit lands in data_out[127].
    - After the 128th falling edge → HOLD.
  - HOLD: CS=1, SCLK=0, for DIV cycles → DONE.
  - DONE: one cycle. done=1, busy=0, data_out loaded from the receive register → IDLE.
- Mode 0 framing: slave samples MOSI on SCLK rising; master samples MISO on SCLK rising.
- start while busy is ignored, with no queueing. start held high in the DONE→IDLE cycle is accepted on the following IDLE cycle.
- Bit counter width: clog2(128+32·8+TURN+1). Divider counter: clog2(DIV+1).
- rst asserted mid-transaction: immediate return to reset values; the partial receive register is discarded.

## Timing
- Transaction bits: B = W+TURN+128 (Nk=4, TURN=1: B=385).
- Latency: done high exactly 1+DIV+2·DIV·B clk cycles after the edge that samples start.
  - Worked example (Nk=4, DIV=2, TURN=1): 1+2+2·2·385 = 1543 cycles.
- CS low from the cycle after start acceptance through the last READ falling edge. Then high for ≥DIV cycles before done.
- MOSI is stable ≥DIV cycles before and after every SCLK rising edge.

## Configuration
- AES_SPI_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in any state except IDLE/DONE → next cycle CS=1, SCLK=0, MOSI=0 → HOLD → IDLE.
  - done is not pulsed and data_out is unchanged.
- Not defined: no abort port; every accepted transaction runs to done.

## Structure
- aes_spi_pkg holds:
  - state enum {IDLE, SETUP, WRITE, TURN, READ, HOLD, DONE};
  - constants BLOCK_BITS=128;
  - function key_bits(Nk)=32·Nk.
- One sub-module: spi_clk_div (DIV-cycle half-period counter). It emits rise/fall strobes that the FSM uses to toggle SCLK, shift MOSI and sample MISO.

## Test plan
- FIPS-197 vector, Nk=4, DIV=2, TURN=1, behavioral slave returns the AES result:
  - stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f;
  - expect data_out=69c4e0d86a7b0430d8cdb78070b4c55a, done at cycle 1543.
- Bus monitor, same run: first 256 bits on MOSI at SCLK rising edges equal pt‖key; exactly 385 SCLK rising edges while CS low.
- start pulsed again at cycle 100 of a transaction:
  - no effect on the current transaction;
  - second transaction only after a new start in IDLE.
- rst deasserted-low at cycle 700 mid-WRITE:
  - all outputs at reset values asynchronously;
  - a new transaction after release completes correctly.
- DIV=1, TURN=0, Nk=8, slave returns all-ones: data_out=all ones, done at 1+1+2·512=1026.
- AES_SPI_ABORT_EN defined, abort at cycle 400: CS=1 next cycle, no done pulse, data_out retains the previous value, busy low within DIV+2 cycles.
